// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: d = a - b - bin, DIGIT bits per clock, LSB slice first.
// Define SERIAL_SUB_OVF_EN to enable the registered signed-overflow flag (ovf is 0 otherwise).
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;

    logic [DIGIT-1:0] slice;
    logic             slice_br;
    logic [WIDTH-1:0] res_next;

`ifdef SERIAL_SUB_OVF_EN
    logic sa_q, sa_d;
    logic sb_q, sb_d;
    logic ovf_q, ovf_d;
`endif

    // Ripple borrow across one DIGIT-bit slice, seeded from the borrow flop.
    always_comb begin
        slice    = '0;
        slice_br = br_q;
        for (int i = 0; i < DIGIT; i++) begin
            slice[i] = a_sh_q[i] ^ b_sh_q[i] ^ slice_br;
            slice_br = (~a_sh_q[i] & b_sh_q[i]) | (~a_sh_q[i] & slice_br) | (b_sh_q[i] & slice_br);
        end
    end

    assign res_next = (res_q >> DIGIT) | (WIDTH'(slice) << (WIDTH - DIGIT));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        br_d    = br_q;
        done_d  = 1'b0;
        d_d     = d_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        sa_d    = sa_q;
        sb_d    = sb_q;
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef SERIAL_SUB_OVF_EN
                    sa_d    = a[WIDTH-1];
                    sb_d    = b[WIDTH-1];
`endif
                end
            end
            RUN: begin
                a_sh_d = a_sh_q >> DIGIT;
                b_sh_d = b_sh_q >> DIGIT;
                res_d  = res_next;
                br_d   = slice_br;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    d_d     = res_next;
                    bout_d  = slice_br;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
`ifdef SERIAL_SUB_OVF_EN
                    // Differing operand signs overflow when the result sign departs from a's.
                    ovf_d   = (sa_q != sb_q) && (res_next[WIDTH-1] != sa_q);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            done_q  <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            br_q    <= br_d;
            done_q  <= done_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign d    = d_q;
    assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_q;
`else
    assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor: a bit-serial (DIGIT=1) and a nibble (DIGIT=4) instance.
// Expected ovf follows SERIAL_SUB_OVF_EN as seen by this compile.
module tb_serial_subtractor;

    logic       clk;
    logic       rst;
    logic       start1, bin1, busy1, done1, bout1, ovf1;
    logic [7:0] a1, b1, d1;
    logic       start4, bin4, busy4, done4, bout4, ovf4;
    logic [7:0] a4, b4, d4;

    int checkCount = 0;
    int failCount  = 0;

`ifdef SERIAL_SUB_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    serial_subtractor #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .d(d1), .bout(bout1), .ovf(ovf1)
    );

    serial_subtractor #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .d(d4), .bout(bout4), .ovf(ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Runs one operation on the DIGIT=1 instance; reports edges from capture to done and busy cycles.
    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                                 output int lat, output int busyCnt);
        @(negedge clk);
        a1 = av; b1 = bv; bin1 = bi; start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        lat = 0;
        busyCnt = busy1 ? 1 : 0;
        while (!done1 && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy1) busyCnt++;
        end
    endtask

    initial begin
        int lat, busyCnt, doneSeen;
        rst = 1'b1;
        start1 = 0; a1 = 0; b1 = 0; bin1 = 0;
        start4 = 0; a4 = 0; b4 = 0; bin4 = 0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy", busy1, 0);
        checkOutput("rst_done", done1, 0);
        checkOutput("rst_d", d1, 8'h00);
        checkOutput("rst_bout", bout1, 0);
        checkOutput("rst_ovf", ovf1, 0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(8'h05, 8'h03, 1'b0, lat, busyCnt);
        checkOutput("t1_lat", lat, 8);
        checkOutput("t1_busycycles", busyCnt, 8);
        checkOutput("t1_d", d1, 8'h02);
        checkOutput("t1_bout", bout1, 0);
        checkOutput("t1_ovf", ovf1, 0);
        checkOutput("t1_busy_at_done", busy1, 0);
        @(posedge clk);
        #1;
        checkOutput("t1_done_pulse", done1, 0);
        checkOutput("t1_d_hold", d1, 8'h02);

        applyStimulus(8'h00, 8'h01, 1'b1, lat, busyCnt);
        checkOutput("t2_lat", lat, 8);
        checkOutput("t2_d", d1, 8'hFE);
        checkOutput("t2_bout", bout1, 1);
        checkOutput("t2_ovf", ovf1, 0);

        applyStimulus(8'h80, 8'h01, 1'b0, lat, busyCnt);
        checkOutput("t3_d", d1, 8'h7F);
        checkOutput("t3_bout", bout1, 0);
        checkOutput("t3_ovf", ovf1, {31'd0, OVF_ON});

        // Nibble-wide instance: two slices per operation.
        @(negedge clk);
        a4 = 8'h3C; b4 = 8'h3C; bin4 = 1'b1; start4 = 1'b1;
        @(posedge clk);
        #1 start4 = 1'b0;
        checkOutput("t4_busy", busy4, 1);
        lat = 0;
        while (!done4 && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("t4_lat", lat, 2);
        checkOutput("t4_d", d4, 8'hFF);
        checkOutput("t4_bout", bout4, 1);
        checkOutput("t4_ovf", ovf4, 0);

        // Start while busy is ignored; start held across done captures in the done cycle.
        @(negedge clk);
        a1 = 8'h10; b1 = 8'h01; bin1 = 1'b0; start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        a1 = 8'hFF; b1 = 8'h00; start1 = 1'b1;
        @(posedge clk);
        #1;
        a1 = 8'h20; b1 = 8'h30; bin1 = 1'b0;
        lat = 4;
        while (!done1 && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("t5_lat", lat, 8);
        checkOutput("t5_d_first", d1, 8'h0F);
        checkOutput("t5_bout_first", bout1, 0);
        @(posedge clk);
        #1 start1 = 1'b0;
        checkOutput("t5_recapture_busy", busy1, 1);
        checkOutput("t5_d_held", d1, 8'h0F);
        lat = 0;
        while (!done1 && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("t5_lat2", lat, 8);
        checkOutput("t5_d_second", d1, 8'hF0);
        checkOutput("t5_bout_second", bout1, 1);

        // Reset mid-operation aborts immediately with no done pulse.
        applyStimulus(8'h05, 8'h03, 1'b0, lat, busyCnt);
        @(negedge clk);
        a1 = 8'h77; b1 = 8'h11; bin1 = 1'b0; start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checkOutput("t6_busy", busy1, 0);
        checkOutput("t6_done", done1, 0);
        checkOutput("t6_d", d1, 8'h00);
        checkOutput("t6_bout", bout1, 0);
        checkOutput("t6_ovf", ovf1, 0);
        @(negedge clk);
        rst = 1'b0;
        doneSeen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done1) doneSeen++;
        end
        checkOutput("t6_no_done", doneSeen, 0);
        applyStimulus(8'h05, 8'h03, 1'b0, lat, busyCnt);
        checkOutput("t6_fresh_lat", lat, 8);
        checkOutput("t6_fresh_d", d1, 8'h02);
        checkOutput("t6_fresh_bout", bout1, 0);

        $display("test done: total=%0d bad=%0d", checkCount, failCount);
        $finish;
    end

endmodule
